vga_timing_monitor: RTL and testbench
=====================================

# vga_timing_monitor

Receive-side checker for the 640x480 VGA stream our designs drive onto the Tiny VGA Pmod. It samples the 8-bit Pmod bus in the pixel clock domain and detects hsync and vsync start edges. It measures line period, lines per frame and lit-pixel count, and runs a lock state machine against the nominal timing. It sits on the bench or on a loopback path beside the video generator and gives a self-check of sync timing without a monitor.

## Interface
- H_TOTAL, 800: expected pixel clocks between hsync start edges.
- V_TOTAL, 525: expected hsync start edges between vsync start edges.
- SYNC_ACTIVE, 0: active level of both hsync and vsync. Negative sync.

- clk  in  1  pixel clock. The same clock drives the video source.
- rst_n  in  1  reset. Asynchronous, active-low.
- vga_in  in  8  Pmod bus. Bit map: [0]=R1, [1]=G1, [2]=B1, [3]=vsync, [4]=R0, [5]=G0, [6]=B0, [7]=hsync.
- locked  out  1  stream matches H_TOTAL/V_TOTAL.
- line_period  out  11  clocks between the last two hsync start edges. Saturates at 2047.
- frame_lines  out  11  hsync starts in the last complete frame. Saturates at 2047.
- lit_count  out  19  cycles in the last frame with any colour bit set. Saturates at 524287.
- frame_strobe  out  1  one-cycle pulse when frame_lines and lit_count update.
- err_count  out  8  lock-loss events. Saturates at 255.

## Operation
- Input stage: s1 <= vga_in and s2 <= s1 on every edge; no further synchronisation, because the source is in the same clock domain.
- Edge detects:
  - hs_start = (s1[7]==SYNC_ACTIVE) && (s2[7]!=SYNC_ACTIVE).
  - vs_start is the same test on bit 3.
- Pixel counter hcnt (11b):
  - On hs_start: line_period <= sat(hcnt+1), hcnt <= 0.
  - Otherwise: hcnt <= sat(hcnt+1).
  - Result: an 800-clock line reads 800.
- Line counter lcnt (11b):
  - Incremented (saturating) on each hs_start.
  - On vs_start: frame_lines <= lcnt plus 1 if hs_start is in the same cycle, then lcnt <= 0. A simultaneous hsync start counts into the ending frame.
- Lit counter:
  - Adds 1 on each cycle where any of s1 bits {0,1,2,4,5,6} is set.
  - On vs_start: lit_count <= accumulated value (including the current cycle), accumulator cleared, frame_strobe <= 1.
- bad_frame flag:
  - Set on any hs_start with sat(hcnt+1) != H_TOTAL.
  - Cleared on vs_start, after it has been evaluated.
- Lock FSM states: SEARCH (reset), CHECK, LOCKED.
  - SEARCH: vs_start -> CHECK. The partial frame is discarded.
  - CHECK: vs_start with !bad_frame (including the current hs_start if simultaneous) and frame_lines value == V_TOTAL -> LOCKED; otherwise stay in CHECK.
  - LOCKED, first-priority error: hs_start with period != H_TOTAL -> CHECK, err_count+1.
  - LOCKED, hsync loss: hcnt reaches H_TOTAL without hs_start -> CHECK, err_count+1.
  - LOCKED, vsync loss: lcnt exceeds V_TOTAL without vs_start -> CHECK, err_count+1.
  - LOCKED, frame-length error: vs_start with line count != V_TOTAL -> CHECK, err_count+1.
  - Multiple error conditions in one cycle count as one error.
- locked = (state == LOCKED), registered.

## Timing
- Reset values: all outputs 0, hcnt/lcnt/accumulator 0, state SEARCH, s1/s2 = 0.
- Reset is asynchronous on assertion. Mid-operation reset clears everything immediately and relock starts from SEARCH.
- Latency: a sync level first sampled into s1 on edge k gives hs_start/vs_start during the cycle after k. The affected outputs (line_period, frame_lines, lit_count, locked, err_count, frame_strobe) update on edge k+1.
- frame_strobe is high for exactly one cycle per vs_start, in every FSM state.
- Minimum time to lock: from the second vs_start after reset, i.e. one complete frame after the first vs_start. locked rises on edge k+1 of that vs_start.
- Counters stop at their maximum and never wrap. err_count holds at 255.

## Test plan
- Nominal 640x480 stream, negative sync, green on for the 640x480 active area: after the second vsync start, locked=1, line_period=800, frame_lines=525, lit_count=307200, frame_strobe one pulse per frame.
- One 801-clock line while locked: at that hs_start, locked->0, err_count=1, line_period=801. Relock after the next complete good frame.
- hsync held inactive while locked: locked drops on the cycle hcnt reaches 800, err_count+1. hcnt saturates at 2047 and line_period holds its old value.
- rst_n pulsed low mid-frame: all outputs read 0 asynchronously, then the lock sequence repeats exactly as in the nominal case.
- hsync and vsync start edges forced into the same cycle: frame_lines counts that line (525, not 524); no error and lock is retained.
- 300 back-to-back injected line-length errors: err_count stops at 255 and locked stays 0.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side sync checker for the Tiny VGA Pmod stream.
// Measures line period, lines per frame and lit pixels, and tracks lock against nominal timing.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        locked,
    output logic [10:0] line_period,
    output logic [10:0] frame_lines,
    output logic [18:0] lit_count,
    output logic        frame_strobe,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    state_t state;
    logic [7:0] s1, s2;
    logic [10:0] hcnt, lcnt, hcnt_inc, lcnt_inc, lines_now;
    logic [18:0] acc, acc_inc;
    logic hs_start, vs_start, lit, bad_frame, bad_line, bad_now, err;
    always_comb begin
        hs_start  = (s1[7] == SYNC_ACTIVE) && (s2[7] != SYNC_ACTIVE);
        vs_start  = (s1[3] == SYNC_ACTIVE) && (s2[3] != SYNC_ACTIVE);
        lit       = |{s1[6:4], s1[2:0]};
        hcnt_inc  = (&hcnt) ? hcnt : hcnt + 11'd1;
        lcnt_inc  = (&lcnt) ? lcnt : lcnt + 11'd1;
        acc_inc   = (&acc) ? acc : acc + 19'(lit);
        // a start edge coinciding with vsync belongs to the frame that is ending
        lines_now = hs_start ? lcnt_inc : lcnt;
        bad_line  = hs_start && (hcnt_inc != HT);
        bad_now   = bad_frame || bad_line;
        err       = bad_line || (!hs_start && hcnt == HT) || (!vs_start && lcnt > VT)
                 || (vs_start && lines_now != VT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= '0;
            s2           <= '0;
            hcnt         <= '0;
            lcnt         <= '0;
            acc          <= '0;
            bad_frame    <= 1'b0;
            line_period  <= '0;
            frame_lines  <= '0;
            lit_count    <= '0;
            frame_strobe <= 1'b0;
            err_count    <= '0;
            locked       <= 1'b0;
            state        <= SEARCH;
        end else begin
            s1           <= vga_in;
            s2           <= s1;
            hcnt         <= hs_start ? '0 : hcnt_inc;
            lcnt         <= vs_start ? '0 : lines_now;
            acc          <= vs_start ? '0 : acc_inc;
            bad_frame    <= vs_start ? 1'b0 : bad_now;
            frame_strobe <= vs_start;
            if (hs_start) line_period <= hcnt_inc;
            if (vs_start) begin
                frame_lines <= lines_now;
                lit_count   <= acc_inc;
            end
            case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vs_start) state <= CHECK;
                end
                CHECK: begin
                    locked <= vs_start && !bad_now && lines_now == VT;
                    if (vs_start && !bad_now && lines_now == VT) state <= LOCKED;
                end
                LOCKED: begin
                    locked <= !err;
                    if (err) begin
                        state     <= CHECK;
                        err_count <= (&err_count) ? err_count : err_count + 8'd1;
                    end
                end
                default: begin
                    locked <= 1'b0;
                    state  <= SEARCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed scoreboard bench on a reduced 10x6 raster.
module tb_vga_timing_monitor;
    localparam int HT = 10;
    localparam int VT = 6;
    typedef struct {int lines; int lit; bit lock;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] vga_in = 8'h88;
    logic locked, frame_strobe;
    logic [10:0] line_period, frame_lines;
    logic [18:0] lit_count;
    logic [7:0] err_count;
    logic [7:0] prev_err = '0;
    logic [10:0] err_period = '0;
    logic err_locked = 1'b1;
    logic vs_lvl = 1'b1;
    exp_t q[$];
    exp_t e_m;
    int total = 0, bad = 0, pushed = 0, popped = 0;

    vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .SYNC_ACTIVE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .locked(locked),
        .line_period(line_period), .frame_lines(frame_lines), .lit_count(lit_count),
        .frame_strobe(frame_strobe), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && err_count > prev_err) begin
            err_period = line_period;
            err_locked = locked;
        end
        prev_err = err_count;
        if (rst_n && frame_strobe) begin
            chk("strobe_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e_m = q.pop_front();
                popped++;
                chk("frame_lines", frame_lines, e_m.lines);
                chk("lit_count", lit_count, e_m.lit);
                chk("locked_at_strobe", locked, e_m.lock);
            end
        end
    end

    task automatic drive(input bit h, input bit v, input bit g);
        @(negedge clk);
        vga_in = {h, 1'b0, g, 1'b0, v, 1'b0, g, 1'b0};
    endtask

    // vsync falls in line 0 and rises in line 1 at cycle 0 (coincident) or cycle 4
    task automatic line(input int l, input int len, input bit co, input bit g, input bit hp);
        int off = co ? 0 : 4;
        for (int c = 0; c < len; c++) begin
            if (c == off && l == 0) vs_lvl = 1'b0;
            if (c == off && l == 1) vs_lvl = 1'b1;
            drive(!(hp && c < 2), vs_lvl, g && c >= 2 && c < 8);
        end
    endtask

    task automatic frame(input bit co, input int el, input int elit, input bit elock, input int bl);
        q.push_back('{el, elit, elock});
        pushed++;
        for (int l = 0; l < VT; l++) line(l, l == bl ? HT + 1 : HT, co, l >= 1 && l <= 4, 1'b1);
    endtask

    task automatic reset_seq(input string tag);
        rst_n = 1'b0;
        vga_in = 8'h88;
        vs_lvl = 1'b1;
        #1;
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_line_period"}, line_period, 0);
        chk({tag, "_frame_lines"}, frame_lines, 0);
        chk({tag, "_lit_count"}, lit_count, 0);
        chk({tag, "_frame_strobe"}, frame_strobe, 0);
        chk({tag, "_err_count"}, err_count, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #1 reset_seq("rst");
        frame(1'b0, 1, 0, 1'b0, -1);
        frame(1'b0, VT, 24, 1'b1, -1);
        chk("nominal_locked", locked, 1);
        chk("nominal_period", line_period, HT);
        frame(1'b0, VT, 24, 1'b1, -1);
        frame(1'b0, VT, 24, 1'b1, 2);
        chk("long_err", err_count, 1);
        chk("long_period", err_period, HT + 1);
        chk("long_unlock_at_err", err_locked, 0);
        chk("long_locked", locked, 0);
        frame(1'b0, VT, 24, 1'b0, -1);
        frame(1'b0, VT, 24, 1'b1, -1);
        chk("relock", locked, 1);
        frame(1'b1, VT, 24, 1'b1, -1);
        frame(1'b1, VT, 24, 1'b1, -1);
        frame(1'b0, VT, 24, 1'b1, -1);
        chk("coincide_err", err_count, 1);
        chk("coincide_locked", locked, 1);
        q.push_back('{VT, 24, 1'b1});
        pushed++;
        line(0, HT, 1'b0, 1'b0, 1'b1);
        line(1, HT, 1'b0, 1'b1, 1'b1);
        line(2, 1000, 1'b0, 1'b0, 1'b1);
        chk("stall_period_hold", line_period, HT);
        chk("stall_unlock", locked, 0);
        chk("stall_err", err_count, 2);
        line(2, 1200, 1'b0, 1'b0, 1'b0);
        line(3, HT, 1'b0, 1'b1, 1'b1);
        chk("stall_period_sat", line_period, 2047);
        line(4, HT, 1'b0, 1'b1, 1'b1);
        line(5, HT, 1'b0, 1'b0, 1'b1);
        frame(1'b0, VT, 18, 1'b0, -1);
        frame(1'b0, VT, 24, 1'b1, -1);
        chk("stall_relock", locked, 1);
        chk("stall_err_after", err_count, 2);
        q.push_back('{VT, 24, 1'b1});
        pushed++;
        for (int l = 0; l < 3; l++) line(l, HT, 1'b0, l >= 1, 1'b1);
        #2 reset_seq("midrst");
        frame(1'b0, 1, 0, 1'b0, -1);
        frame(1'b0, VT, 24, 1'b1, -1);
        chk("midrst_relock", locked, 1);
        chk("midrst_err", err_count, 0);
        for (int i = 0; i < 300; i++) begin
            frame(1'b0, VT, 24, 1'b1, 2);
            frame(1'b0, VT, 24, 1'b0, -1);
        end
        chk("sat_err", err_count, 255);
        chk("sat_locked", locked, 0);
        repeat (4) drive(1'b1, 1'b1, 1'b0);
        chk("queue_drained", q.size(), 0);
        chk("strobe_count", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
